mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle sequencer and iterative engine for the RV32M multiply/divide operations flagged by the instruction controller (`md_op_ctrl_o`). It accepts one MDU operation with its 3-bit op code and operands, runs it over 32 iterations (shift-add multiply, restoring divide), and applies RISC-V sign and special-case rules. It returns the 32-bit result through a valid/ready handshake and stalls the pipeline front end while busy. It sits beside the ALU in execute and is instantiated only when `RISCV_M_CORE` is set.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `MDU_OP_WIDTH`, 3: op code width. Encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: async active-high reset.
- `start_i`  in  1: operation request from execute.
- `op_i`  in  MDU_OP_WIDTH: MDU op code, sampled with `start_i`.
- `rs1_i`  in  XLEN: operand 1 (dividend / multiplicand), sampled with `start_i`.
- `rs2_i`  in  XLEN: operand 2 (divisor / multiplier), sampled with `start_i`.
- `flush_i`  in  1: abort the current operation; no result is produced.
- `ready_i`  in  1: writeback accepts the result.
- `valid_o`  out  1: `result_o` is valid.
- `result_o`  out  XLEN: operation result.
- `busy_o`  out  1: FSM is not in IDLE.
- `stall_o`  out  1: combinational stall to the pipeline.

## Operation
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE, `start_i`=1, `flush_i`=0: latch the op and operands.
  - Special case: go directly to DONE with the fast result.
  - Otherwise go to PREP.
- Special cases (DIV/DIVU/REM/REMU only):
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- PREP:
  - Take magnitudes of the signed operands. Signed: MULH both operands, MULHSU rs1 only, DIV/REM both. Unsigned: MUL, MULHU, DIVU, REMU.
  - Record the result sign. Multiply: XOR of the operand signs. Quotient: XOR of the operand signs. Remainder: sign of the dividend.
  - Clear the 6-bit iteration counter and the 64-bit accumulator.
- CALC: 32 iterations, one per cycle; the counter increments each cycle; leave to FIXUP when the count reaches 31.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the accumulator high half; shift right by 1 (64-bit, carry included).
  - Divide: shift {rem, quot} left by 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set the quot LSB.
- FIXUP:
  - Negate the 64-bit product or the 32-bit quotient/remainder (two's complement) if the recorded sign is set.
  - Select: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the result into `result_o`; go to DONE.
- DONE:
  - `valid_o`=1; `result_o` held stable.
  - `ready_i`=1: return to IDLE next cycle.
  - `ready_i`=0: stay in DONE.
- `start_i` is ignored outside IDLE. There is no same-cycle restart from DONE; a new start is accepted the cycle after the return to IDLE.
- `flush_i` in any state: IDLE next cycle, `valid_o`=0 next cycle, latched op discarded. `flush_i` wins over a simultaneous `start_i` or `ready_i`.
- `stall_o` = (IDLE & `start_i`) | (state≠IDLE & ¬(DONE & `ready_i`)).
- `busy_o` = state≠IDLE.

## Timing
- Reset (async, immediate): state IDLE; `valid_o`=0, `busy_o`=0, `result_o`=0, counter=0, accumulator=0. `stall_o` follows `start_i` combinationally.
- Normal op, start accepted in cycle T:
  - PREP in T+1.
  - CALC in T+2..T+33.
  - FIXUP in T+34.
  - `valid_o`=1 from T+35.
- Fast path (special case) accepted in T: `valid_o`=1 at T+1.
- Handshake completes in the cycle with `valid_o` & `ready_i`; `valid_o`=0 the next cycle.
- Reset asserted mid-operation: outputs return to reset values immediately, and no result is produced after release.
- Result is registered; no combinational path from operands to `result_o`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (-3), `ready_i`=1 -> `result_o`=0xFFFFFFEB, `valid_o` exactly at T+35 for one cycle; `stall_o` high T..T+34 and low at T+35.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with `valid_o` at T+1:
  - DIV x/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- `flush_i` at T+12 of a DIVU -> state IDLE at T+13, no `valid_o` ever; a new MUL 3×4 started at T+13 -> 12 at T+48.
- `ready_i` held 0 for 5 cycles after `valid_o` -> `result_o` stable, `stall_o`=1 throughout. `ready_i`=1 -> IDLE next cycle.
- `rst_i` pulsed at T+20 of a MULHU -> all outputs 0 immediately, no result after release.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake bundle between execute and the multiply/divide sequencer.
// dbg_state mirrors the sequencer FSM state for checkers and waveform reading.
interface mdu_if #(
    parameter int XLEN         = 32,
    parameter int MDU_OP_WIDTH = 3
);
    logic                    start_i;
    logic [MDU_OP_WIDTH-1:0] op_i;
    logic [XLEN-1:0]         rs1_i;
    logic [XLEN-1:0]         rs2_i;
    logic                    flush_i;
    logic                    ready_i;
    logic                    valid_o;
    logic [XLEN-1:0]         result_o;
    logic                    busy_o;
    logic                    stall_o;
    logic [2:0]              dbg_state;

    // valid/ready: a result transfers in any cycle with valid_o & ready_i; once raised,
    // valid_o and result_o stay stable until that transfer or a flush/reset.
    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i, ready_i,
        input  valid_o, result_o, busy_o, stall_o, dbg_state
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i, ready_i,
        output valid_o, result_o, busy_o, stall_o, dbg_state
    );
endinterface

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide engine: 32-step shift-add multiply and restoring divide,
// with RISC-V sign handling and single-cycle divide-by-zero / overflow results.
module mdu_sequencer #(
    parameter int XLEN         = 32,
    parameter int MDU_OP_WIDTH = 3
) (
    input logic  clk_i,
    input logic  rst_i,
    mdu_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, PREP = 3'd1, CALC = 3'd2, FIXUP = 3'd3, DONE = 3'd4} state_t;

    localparam logic [MDU_OP_WIDTH-1:0] OP_MUL    = 0;
    localparam logic [MDU_OP_WIDTH-1:0] OP_MULH   = 1;
    localparam logic [MDU_OP_WIDTH-1:0] OP_MULHSU = 2;
    localparam logic [MDU_OP_WIDTH-1:0] OP_MULHU  = 3;
    localparam logic [MDU_OP_WIDTH-1:0] OP_DIV    = 4;
    localparam logic [MDU_OP_WIDTH-1:0] OP_DIVU   = 5;
    localparam logic [MDU_OP_WIDTH-1:0] OP_REM    = 6;
    localparam logic [MDU_OP_WIDTH-1:0] OP_REMU   = 7;
    localparam logic [5:0]              LAST_ITER = 6'(XLEN - 1);

    state_t                  state_q, state_d;
    logic [MDU_OP_WIDTH-1:0] op_q;
    logic [XLEN-1:0]         a_q, b_q, result_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [5:0]              cnt_q;
    logic                    neg_q, rneg_q;

    logic                    in_div, in_rem, in_special;
    logic [XLEN-1:0]         fast_res;
    logic                    sign_a, sign_b, op_is_div;
    logic [XLEN-1:0]         mag_a, mag_b;
    logic [XLEN:0]           mul_sum, div_trial;
    logic [2*XLEN-1:0]       prod_fix;
    logic [XLEN-1:0]         quot_fix, rem_fix, sel_res;

    // Fast path decode on the raw request operands.
    always_comb begin
        in_div     = bus.op_i[2];
        in_rem     = bus.op_i[1];
        in_special = 1'b0;
        fast_res   = '0;
        if (in_div && bus.rs2_i == '0) begin
            in_special = 1'b1;
            fast_res   = in_rem ? bus.rs1_i : '1;
        end else if ((bus.op_i == OP_DIV || bus.op_i == OP_REM) &&
                     bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_i == '1) begin
            in_special = 1'b1;
            fast_res   = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        op_is_div = op_q[2];
        sign_a    = a_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_MULHSU ||
                                    op_q == OP_DIV  || op_q == OP_REM);
        sign_b    = b_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
        mag_a     = sign_a ? (~a_q + 1'b1) : a_q;
        mag_b     = sign_b ? (~b_q + 1'b1) : b_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : '0)};
        // Partial remainder needs XLEN+1 bits after the shift.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                         sel_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   sel_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                sel_res = quot_fix;
            default:                        sel_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bus.stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.stall_o = bus.start_i;
                if (bus.start_i) state_d = in_special ? DONE : PREP;
            end
            PREP: begin
                bus.stall_o = 1'b1;
                state_d     = CALC;
            end
            CALC: begin
                bus.stall_o = 1'b1;
                if (cnt_q == LAST_ITER) state_d = FIXUP;
            end
            FIXUP: begin
                bus.stall_o = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                bus.stall_o = !bus.ready_i;
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else if (!bus.flush_i) begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    op_q <= bus.op_i;
                    a_q  <= bus.rs1_i;
                    b_q  <= bus.rs2_i;
                    if (in_special) result_q <= fast_res;
                end
                PREP: begin
                    a_q    <= mag_a;
                    b_q    <= mag_b;
                    neg_q  <= sign_a ^ sign_b;
                    rneg_q <= sign_a;
                    cnt_q  <= '0;
                    // Divide seeds {rem, quot} with the dividend magnitude in the quotient half.
                    acc_q  <= op_is_div ? {{XLEN{1'b0}}, mag_a} : '0;
                end
                CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (op_is_div) begin
                        if (!div_trial[XLEN])
                            acc_q <= {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        else
                            acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
                    end else begin
                        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                        b_q   <= b_q >> 1;
                    end
                end
                FIXUP: result_q <= sel_res;
                default: ;
            endcase
        end
    end

    assign bus.valid_o   = (state_q == DONE);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.result_o  = result_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, arithmetic, fast path, flush,
// back-pressure and mid-operation reset.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    mdu_if bus ();

    mdu_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op with ready_i=1 and returns the cycles from start to valid_o.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.ready_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        res = bus.result_o;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i = 3'd0; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.flush_i = 1'b0; bus.ready_i = 1'b1;
        #1;
        total_cnt++;
        if (bus.stall_o !== 1'b1) $display("FAIL reset_stall_follows_start got=%b exp=1", bus.stall_o);
        else pass_cnt++;
        bus.start_i = 1'b0;
        #1;
        total_cnt++;
        if ({bus.valid_o, bus.busy_o, bus.stall_o, bus.result_o} !== 35'd0)
            $display("FAIL reset_outputs got v=%b b=%b s=%b r=%h exp all 0",
                     bus.valid_o, bus.busy_o, bus.stall_o, bus.result_o);
        else pass_cnt++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_mul_timing();
        int vcnt = 0;
        int scnt = 0;
        bus.start_i = 1'b1; bus.op_i = 3'd0;
        bus.rs1_i = 32'd7; bus.rs2_i = 32'hFFFF_FFFD; bus.ready_i = 1'b1;
        #1;
        if (bus.stall_o === 1'b1) scnt++;
        step();
        bus.start_i = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (bus.stall_o === 1'b1) scnt++;
            if (bus.valid_o !== 1'b0) vcnt++;
            step();
        end
        total_cnt++;
        if (scnt != 35) $display("FAIL mul_stall_T_to_T34 got=%0d cycles exp=35", scnt);
        else pass_cnt++;
        total_cnt++;
        if (vcnt != 0) $display("FAIL mul_early_valid got=%0d cycles exp=0", vcnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid_o !== 1'b1) $display("FAIL mul_valid_T35 got=%b exp=1", bus.valid_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_o !== 32'hFFFF_FFEB) $display("FAIL mul_result got=%h exp=ffffffeb", bus.result_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.stall_o !== 1'b0) $display("FAIL mul_stall_T35 got=%b exp=0", bus.stall_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL mul_after_handshake got v=%b b=%b exp 0 0", bus.valid_o, bus.busy_o);
        else pass_cnt++;
    endtask

    task automatic test_multiply();
        logic [2:0]  ops[4] = '{3'd1, 3'd2, 3'd3, 3'd1};
        logic [31:0] as[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [31:0] bs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] ex[4]  = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res);
            total_cnt++;
            if (res !== ex[i] || lat != 35)
                $display("FAIL mul_vec%0d op=%0d got=%h lat=%0d exp=%h lat=35", i, ops[i], res, lat, ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops[7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
        logic [31:0] as[7]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'hFFFF_FFFF, 32'd7, 32'd7};
        logic [31:0] bs[7]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] ex[7]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res);
            total_cnt++;
            if (res !== ex[i] || lat != 35)
                $display("FAIL div_vec%0d op=%0d got=%h lat=%0d exp=%h lat=35", i, ops[i], res, lat, ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[5] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
        logic [31:0] as[5]  = '{32'd5, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[5]  = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'd0};
        int          el[5]  = '{1, 1, 1, 1, 35};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res);
            total_cnt++;
            if (res !== ex[i] || lat != el[i])
                $display("FAIL special_vec%0d op=%0d got=%h lat=%0d exp=%h lat=%0d",
                         i, ops[i], res, lat, ex[i], el[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        int vcnt = 0;
        int lat;
        logic [31:0] res;
        bus.start_i = 1'b1; bus.op_i = 3'd5; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3;
        bus.ready_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 1; k < 12; k++) begin
            if (bus.valid_o !== 1'b0) vcnt++;
            step();
        end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        total_cnt++;
        if (bus.dbg_state !== 3'd0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || vcnt != 0)
            $display("FAIL flush_to_idle got state=%0d busy=%b valid=%b early_valid=%0d exp 0 0 0 0",
                     bus.dbg_state, bus.busy_o, bus.valid_o, vcnt);
        else pass_cnt++;
        do_op(3'd0, 32'd3, 32'd4, lat, res);
        total_cnt++;
        if (res !== 32'd12 || lat != 35)
            $display("FAIL flush_restart got=%h lat=%0d exp=0000000c lat=35", res, lat);
        else pass_cnt++;
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        step();
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        total_cnt++;
        if (bus.busy_o !== 1'b0) $display("FAIL flush_beats_start got busy=%b exp=0", bus.busy_o);
        else pass_cnt++;
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.rs1_i = 32'd5; bus.rs2_i = 32'd0;
        bus.ready_i = 1'b0;
        step();
        bus.start_i = 1'b0; bus.flush_i = 1'b1; bus.ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        total_cnt++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL flush_in_done got v=%b b=%b exp 0 0", bus.valid_o, bus.busy_o);
        else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        int w = 0;
        int bad = 0;
        bus.start_i = 1'b1; bus.op_i = 3'd5; bus.rs1_i = 32'd100; bus.rs2_i = 32'd7;
        bus.ready_i = 1'b0;
        step();
        bus.start_i = 1'b0;
        while (bus.valid_o !== 1'b1 && w < 60) begin
            step();
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            if (bus.valid_o !== 1'b1 || bus.stall_o !== 1'b1 || bus.result_o !== 32'd14) bad++;
            step();
        end
        total_cnt++;
        if (bad != 0 || w >= 60)
            $display("FAIL backpressure_hold got bad_cycles=%0d wait=%0d exp 0 cycles", bad, w);
        else pass_cnt++;
        bus.ready_i = 1'b1;
        #1;
        total_cnt++;
        if (bus.stall_o !== 1'b0) $display("FAIL backpressure_release_stall got=%b exp=0", bus.stall_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.dbg_state !== 3'd0 || bus.valid_o !== 1'b0)
            $display("FAIL backpressure_idle got state=%0d valid=%b exp 0 0", bus.dbg_state, bus.valid_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int vcnt = 0;
        bus.start_i = 1'b1; bus.op_i = 3'd3; bus.rs1_i = 32'hFFFF_FFFF; bus.rs2_i = 32'hFFFF_FFFF;
        bus.ready_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 1; k < 20; k++) step();
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.valid_o, bus.busy_o, bus.stall_o, bus.result_o} !== 35'd0 || bus.dbg_state !== 3'd0)
            $display("FAIL reset_mid_outputs got v=%b b=%b s=%b r=%h st=%0d exp all 0",
                     bus.valid_o, bus.busy_o, bus.stall_o, bus.result_o, bus.dbg_state);
        else pass_cnt++;
        step();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) vcnt++;
            step();
        end
        total_cnt++;
        if (vcnt != 0) $display("FAIL reset_mid_no_result got=%0d active cycles exp=0", vcnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_multiply();
        test_divide();
        test_special();
        test_flush();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
